// File: rtl/decode_stage.sv
// Registered instruction-decode stage: decodes fetched instructions into register/address
// fields and passes them on through a valid/ready pipeline with a 2-entry skid buffer.
module decode_stage #(
  parameter int INSTR_W = 16,
  parameter int REG_W   = 3,
  parameter int ADDR_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_opcode,
  output logic               out_mode,
  output logic [REG_W-1:0]   out_reg1,
  output logic [REG_W-1:0]   out_reg2,
  output logic [REG_W-1:0]   out_reg3,
  output logic [ADDR_W-1:0]  out_data_mem,
  output logic [ADDR_W-1:0]  out_instr_mem,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               out_halt,
  output logic               halted
);

  localparam int P = INSTR_W - 6;

  typedef struct packed {
    logic [3:0]        opcode;
    logic              mode;
    logic [REG_W-1:0]  reg1;
    logic [REG_W-1:0]  reg2;
    logic [REG_W-1:0]  reg3;
    logic [ADDR_W-1:0] dataMem;
    logic [ADDR_W-1:0] instrMem;
    logic [ADDR_W-1:0] pc;
    logic              halt;
  } entry_t;

  entry_t w_dec;
  entry_t r_out;
  entry_t r_skid;
  logic   r_outValid;
  logic   r_skidValid;
  logic   r_halted;
  logic   w_accept;

  // Field decode on the incoming instruction; unused fields stay zero.
  always_comb begin
    w_dec        = '0;
    w_dec.opcode = in_instr[INSTR_W-1 -: 4];
    w_dec.mode   = in_instr[INSTR_W-5];
    w_dec.pc     = in_pc;
    case (w_dec.opcode)
      4'h0: begin
        w_dec.reg1 = in_instr[P -: REG_W];
        if (w_dec.mode) w_dec.dataMem = in_instr[P-REG_W -: ADDR_W];
        else            w_dec.reg2    = in_instr[P-REG_W -: REG_W];
      end
      4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'hA: begin
        w_dec.reg1 = in_instr[P -: REG_W];
        w_dec.reg2 = in_instr[P-REG_W -: REG_W];
        if (w_dec.mode) w_dec.dataMem = in_instr[ADDR_W-1:0];
        else            w_dec.reg3    = in_instr[P-2*REG_W -: REG_W];
      end
      4'h5, 4'h6, 4'h9: begin
        if (w_dec.mode) w_dec.dataMem = in_instr[P -: ADDR_W];
        else            w_dec.reg1    = in_instr[P -: REG_W];
      end
      4'hB: begin
        w_dec.reg1    = in_instr[P -: REG_W];
        w_dec.dataMem = in_instr[P-REG_W -: ADDR_W];
      end
      4'hC: begin
        w_dec.instrMem = in_instr[P -: ADDR_W];
        w_dec.reg1     = in_instr[P-ADDR_W -: REG_W];
      end
      4'hD: w_dec.instrMem = in_instr[P -: ADDR_W];
      4'hE: begin
        w_dec.reg1     = in_instr[P -: REG_W];
        w_dec.instrMem = in_instr[P-REG_W -: ADDR_W];
      end
      default: w_dec.halt = 1'b1;
    endcase
  end

  // in_ready depends only on flops, so there is no path from out_ready.
  assign in_ready = !r_skidValid && !r_halted;
  assign w_accept = in_valid && in_ready;

  // Skid only ever fills while the output register is stalled, so draining it first
  // keeps order; while it is full in_ready is low and nothing new can arrive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_skid      <= '0;
      r_outValid  <= 1'b0;
      r_skidValid <= 1'b0;
      r_halted    <= 1'b0;
    end else if (flush) begin
      r_out       <= '0;
      r_outValid  <= 1'b0;
      r_skidValid <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      if (!r_outValid || out_ready) begin
        if (r_skidValid) begin
          r_out       <= r_skid;
          r_outValid  <= 1'b1;
          r_skidValid <= 1'b0;
        end else begin
          r_outValid <= w_accept;
          if (w_accept) r_out <= w_dec;
        end
      end else if (w_accept) begin
        r_skid      <= w_dec;
        r_skidValid <= 1'b1;
      end
      if (w_accept && w_dec.halt) r_halted <= 1'b1;
    end
  end

  assign out_valid     = r_outValid;
  assign out_opcode    = r_out.opcode;
  assign out_mode      = r_out.mode;
  assign out_reg1      = r_out.reg1;
  assign out_reg2      = r_out.reg2;
  assign out_reg3      = r_out.reg3;
  assign out_data_mem  = r_out.dataMem;
  assign out_instr_mem = r_out.instrMem;
  assign out_pc        = r_out.pc;
  assign out_halt      = r_out.halt;
  assign halted        = r_halted;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: hand-computed decode table, directed handshake
// corner cases, then a randomized stream against a queue-based reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [4:0]  in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic        out_mode;
  logic [2:0]  out_reg1, out_reg2, out_reg3;
  logic [4:0]  out_data_mem, out_instr_mem, out_pc;
  logic        out_halt;
  logic        halted;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct packed {
    logic [3:0] op;
    logic       mode;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [2:0] r3;
    logic [4:0] dm;
    logic [4:0] im;
    logic [4:0] pc;
    logic       halt;
  } fields_t;

  typedef struct {
    logic [15:0] instr;
    logic [4:0]  pc;
    fields_t     exp;
  } vec_t;

  fields_t dutFields;
  assign dutFields = {out_opcode, out_mode, out_reg1, out_reg2, out_reg3,
                      out_data_mem, out_instr_mem, out_pc, out_halt};

  decode_stage #(.INSTR_W(16), .REG_W(3), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_mode(out_mode),
    .out_reg1(out_reg1), .out_reg2(out_reg2), .out_reg3(out_reg3),
    .out_data_mem(out_data_mem), .out_instr_mem(out_instr_mem),
    .out_pc(out_pc), .out_halt(out_halt), .halted(halted)
  );

  always #5 clk = ~clk;

  // Reference decode from the field rules, using shifts on the raw word.
  function automatic int fieldAt(input logic [15:0] instr, input int a);
    return (int'(instr) >> (8 - a)) & 7;
  endfunction

  function automatic int addrAt(input logic [15:0] instr, input int a);
    return (int'(instr) >> (6 - a)) & 31;
  endfunction

  function automatic fields_t modelDecode(input logic [15:0] instr, input logic [4:0] pc);
    fields_t f;
    int op;
    int mode;
    f    = '0;
    op   = int'(instr) >> 12;
    mode = (int'(instr) >> 11) & 1;
    f.op   = 4'(op);
    f.mode = 1'(mode);
    f.pc   = pc;
    case (op)
      0: begin
        f.r1 = 3'(fieldAt(instr, 0));
        if (mode == 1) f.dm = 5'(addrAt(instr, 3));
        else           f.r2 = 3'(fieldAt(instr, 3));
      end
      1, 2, 3, 4, 7, 8, 10: begin
        f.r1 = 3'(fieldAt(instr, 0));
        f.r2 = 3'(fieldAt(instr, 3));
        if (mode == 1) f.dm = 5'(int'(instr) & 31);
        else           f.r3 = 3'(fieldAt(instr, 6));
      end
      5, 6, 9: begin
        if (mode == 1) f.dm = 5'(addrAt(instr, 0));
        else           f.r1 = 3'(fieldAt(instr, 0));
      end
      11: begin
        f.r1 = 3'(fieldAt(instr, 0));
        f.dm = 5'(addrAt(instr, 3));
      end
      12: begin
        f.im = 5'(addrAt(instr, 0));
        f.r1 = 3'(fieldAt(instr, 5));
      end
      13: f.im = 5'(addrAt(instr, 0));
      14: begin
        f.r1 = 3'(fieldAt(instr, 0));
        f.im = 5'(addrAt(instr, 3));
      end
      default: f.halt = 1'b1;
    endcase
    return f;
  endfunction

  function automatic vec_t makeVec(input logic [15:0] instr, input logic [4:0] pc,
                                   input logic [3:0] op, input logic mode,
                                   input logic [2:0] r1, input logic [2:0] r2,
                                   input logic [2:0] r3, input logic [4:0] dm,
                                   input logic [4:0] im);
    vec_t v;
    v.instr = instr;
    v.pc    = pc;
    v.exp   = {op, mode, r1, r2, r3, dm, im, pc, 1'b0};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic [4:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  vec_t    vecs[12];
  fields_t q[$];
  bit      mHalted;
  bit      acc;
  bit      pop;

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    applyStimulus(1'b0, 16'h0, 5'h0);

    vecs[0]  = makeVec(16'h1234, 5'd3,  4'h1, 1'b0, 3'd2, 3'd1, 3'd5, 5'h00, 5'h00);
    vecs[1]  = makeVec(16'hE2A8, 5'd4,  4'hE, 1'b0, 3'd2, 3'd0, 3'd0, 5'h00, 5'h15);
    vecs[2]  = makeVec(16'h0ABC, 5'd5,  4'h0, 1'b1, 3'd2, 3'd0, 3'd0, 5'h17, 5'h00);
    vecs[3]  = makeVec(16'h0355, 5'd6,  4'h0, 1'b0, 3'd3, 3'd2, 3'd0, 5'h00, 5'h00);
    vecs[4]  = makeVec(16'h1F5A, 5'd7,  4'h1, 1'b1, 3'd7, 3'd2, 3'd0, 5'h1A, 5'h00);
    vecs[5]  = makeVec(16'h5600, 5'd8,  4'h5, 1'b0, 3'd6, 3'd0, 3'd0, 5'h00, 5'h00);
    vecs[6]  = makeVec(16'h6CF0, 5'd9,  4'h6, 1'b1, 3'd0, 3'd0, 3'd0, 5'h13, 5'h00);
    vecs[7]  = makeVec(16'hB6D2, 5'd10, 4'hB, 1'b0, 3'd6, 3'd0, 3'd0, 5'h1A, 5'h00);
    vecs[8]  = makeVec(16'hC5E8, 5'd11, 4'hC, 1'b0, 3'd5, 3'd0, 3'd0, 5'h00, 5'h17);
    vecs[9]  = makeVec(16'hD7C0, 5'd12, 4'hD, 1'b0, 3'd0, 3'd0, 3'd0, 5'h00, 5'h1F);
    vecs[10] = makeVec(16'h9300, 5'd13, 4'h9, 1'b0, 3'd3, 3'd0, 3'd0, 5'h00, 5'h00);
    vecs[11] = makeVec(16'hA49C, 5'd31, 4'hA, 1'b0, 3'd4, 3'd4, 3'd7, 5'h00, 5'h00);

    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_halted", 32'(halted), 32'd0);
    checkOutput("reset_fields", 32'(dutFields), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back table stream with out_ready held high.
    @(negedge clk);
    applyStimulus(1'b1, vecs[0].instr, vecs[0].pc);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput($sformatf("table%0d_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("table%0d_fields", i), 32'(dutFields), 32'(vecs[i].exp));
      if (i < 11) applyStimulus(1'b1, vecs[i+1].instr, vecs[i+1].pc);
      else        applyStimulus(1'b0, 16'h0, 5'h0);
    end
    @(negedge clk);
    checkOutput("table_drained", 32'(out_valid), 32'd0);

    // Stall: second entry goes to skid, third is held off until release.
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'h1234, 5'd1);
    @(negedge clk);
    checkOutput("stall_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_ready1", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 16'h5600, 5'd2);
    @(negedge clk);
    checkOutput("stall_ready2", 32'(in_ready), 32'd0);
    checkOutput("stall_hold1", 32'(dutFields), 32'(modelDecode(16'h1234, 5'd1)));
    applyStimulus(1'b1, 16'h9300, 5'd4);
    @(negedge clk);
    checkOutput("stall_ready3", 32'(in_ready), 32'd0);
    checkOutput("stall_hold2", 32'(dutFields), 32'(modelDecode(16'h1234, 5'd1)));
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_second", 32'(dutFields), 32'(modelDecode(16'h5600, 5'd2)));
    checkOutput("stall_ready4", 32'(in_ready), 32'd1);
    @(negedge clk);
    checkOutput("stall_third", 32'(dutFields), 32'(modelDecode(16'h9300, 5'd4)));
    applyStimulus(1'b0, 16'h0, 5'h0);
    @(negedge clk);
    checkOutput("stall_empty", 32'(out_valid), 32'd0);

    // BRANCH then HALT, latch, then flush clears it.
    applyStimulus(1'b1, 16'hE2A8, 5'd7);
    @(negedge clk);
    checkOutput("branch_fields", 32'(dutFields),
                32'({4'hE, 1'b0, 3'd2, 3'd0, 3'd0, 5'h00, 5'h15, 5'd7, 1'b0}));
    applyStimulus(1'b1, 16'hF000, 5'd8);
    @(negedge clk);
    checkOutput("halt_fields", 32'(dutFields),
                32'({4'hF, 1'b0, 3'd0, 3'd0, 3'd0, 5'h00, 5'h00, 5'd8, 1'b1}));
    checkOutput("halt_valid", 32'(out_valid), 32'd1);
    checkOutput("halt_latched", 32'(halted), 32'd1);
    checkOutput("halt_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 16'h1234, 5'd9);
    @(negedge clk);
    checkOutput("halt_blocks", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 16'h0, 5'h0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_halted", 32'(halted), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);

    // Flush with both entries full and a same-cycle input.
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'h1234, 5'd1);
    @(negedge clk);
    applyStimulus(1'b1, 16'h5600, 5'd2);
    @(negedge clk);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    applyStimulus(1'b1, 16'h9300, 5'd3);
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(1'b0, 16'h0, 5'h0);
    checkOutput("flushfull_valid", 32'(out_valid), 32'd0);
    checkOutput("flushfull_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("flushfull_dropped", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a stream.
    applyStimulus(1'b1, 16'h1234, 5'd1);
    @(negedge clk);
    applyStimulus(1'b1, 16'h0ABC, 5'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_valid", 32'(out_valid), 32'd0);
    checkOutput("areset_fields", 32'(dutFields), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 5'h0);
    rst_n = 1'b1;

    // Randomized stream against the queue model.
    q.delete();
    mHalted = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checkOutput("rnd_valid", 32'(out_valid), 32'(q.size() > 0));
      checkOutput("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2 && !mHalted));
      checkOutput("rnd_halted", 32'(halted), 32'(mHalted));
      if (q.size() > 0) checkOutput("rnd_fields", 32'(dutFields), 32'(q[0]));
      in_instr = 16'($urandom);
      if (in_instr[15:12] == 4'hF && $urandom_range(3) != 0)
        in_instr[15:12] = 4'($urandom_range(14));
      in_pc     = 5'($urandom);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(29) == 0) || (mHalted && $urandom_range(2) == 0);
      @(posedge clk);
      acc = in_valid && q.size() < 2 && !mHalted;
      pop = q.size() > 0 && out_ready;
      if (flush) begin
        q.delete();
        mHalted = 1'b0;
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          q.push_back(modelDecode(in_instr, in_pc));
          if (in_instr[15:12] == 4'hF) mHalted = 1'b1;
        end
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
